// File: rtl/arb_ram_if.sv
// arb_ram requester bus: per-port req/we/addr/wdata in, one-hot gnt/rvalid plus shared rdata/busy out.
// Address and write data are flattened: port i occupies [i*WIDTH +: WIDTH].
interface arb_ram_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 8,
   parameter int NUM_PORTS  = 2
);
   logic [NUM_PORTS-1:0]            req;
   logic [NUM_PORTS-1:0]            we;
   logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
   logic [NUM_PORTS*DATA_WIDTH-1:0] wdata;
   logic [NUM_PORTS-1:0]            gnt;
   logic [DATA_WIDTH-1:0]           rdata;
   logic [NUM_PORTS-1:0]            rvalid;
   logic                            busy;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rdata, rvalid, busy
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rdata, rvalid, busy
   );
endinterface

// File: rtl/arb_ram.sv
// Round-robin arbitrated single-port RAM, reads return READ_LATENCY cycles after grant; requesters hold req until gnt.
// RAM_CLEAR_ON_RESET_EN: zero-fill sweep after reset, busy=1 and gnt=0 until it completes.
module arb_ram #(
   parameter int ADDR_WIDTH   = 15,
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_PORTS    = 2,
   parameter int READ_LATENCY = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   arb_ram_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [PTR_W:0]   NP       = (PTR_W+1)'(NUM_PORTS);
   localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(NUM_PORTS - 1);

   generate
      if (NUM_PORTS < 1 || NUM_PORTS > 4) begin : g_bad_ports
         $error("arb_ram: NUM_PORTS must be in 1..4");
      end
      if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
         $error("arb_ram: READ_LATENCY must be 1 or 2");
      end
   endgenerate

   logic [PTR_W-1:0]      last_q;
   logic [PTR_W-1:0]      sel;
   logic [PTR_W:0]        cand;
   logic                  found;
   logic [NUM_PORTS-1:0]  gnt_c;
   logic                  busy;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  wr_en;
   logic                  rd_en;
   logic                  clr_wr;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic [NUM_PORTS-1:0]  vld1_q;
   logic [DATA_WIDTH-1:0] dat1_q;

`ifdef RAM_CLEAR_ON_RESET_EN
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   typedef enum logic {S_CLEAR, S_IDLE} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

   // Reset parks the sweep at address 0, so a reset mid-sweep restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clr_wr     = 1'b0;
      busy       = 1'b0;
      case (state_q)
         S_CLEAR: begin
            busy       = 1'b1;
            clr_wr     = 1'b1;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == '1) state_d = S_IDLE;
         end
         default: ;
      endcase
   end

   assign clr_addr = clr_addr_q;
`else
   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

   assign busy     = 1'b0;
   assign clr_wr   = 1'b0;
   assign clr_addr = '0;
`endif

   // Scan forward from the port after the last grant, wrapping modulo NUM_PORTS.
   always_comb begin
      gnt_c = '0;
      sel   = last_q;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand = {1'b0, last_q} + (PTR_W+1)'(k);
         if (cand >= NP) cand = cand - NP;
         if (!found && !busy && bus.req[cand[PTR_W-1:0]]) begin
            found = 1'b1;
            sel   = cand[PTR_W-1:0];
         end
      end
      if (found) gnt_c[sel] = 1'b1;
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (gnt_c[i]) begin
            sel_we    = bus.we[i];
            sel_addr  = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign wr_en   = found & sel_we;
   assign rd_en   = found & ~sel_we;
   assign bus.gnt  = gnt_c;
   assign bus.busy = busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= LAST_RST;
      else if (found) last_q <= sel;
   end

   always_ff @(posedge clk) begin
      if (clr_wr) mem[clr_addr] <= '0;
      else if (wr_en) mem[sel_addr] <= sel_wdata;
   end

   // Read data only moves on a read grant, so rdata holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld1_q <= '0;
         dat1_q <= '0;
      end else begin
         vld1_q <= rd_en ? gnt_c : '0;
         if (rd_en) dat1_q <= mem[sel_addr];
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [NUM_PORTS-1:0]  vld2_q;
         logic [DATA_WIDTH-1:0] dat2_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld2_q <= '0;
               dat2_q <= '0;
            end else begin
               vld2_q <= vld1_q;
               if (|vld1_q) dat2_q <= dat1_q;
            end
         end

         assign bus.rvalid = vld2_q;
         assign bus.rdata  = dat2_q;
      end else begin : g_lat1
         assign bus.rvalid = vld1_q;
         assign bus.rdata  = dat1_q;
      end
   endgenerate
endmodule

// File: tb/tb_arb_ram.sv
// Directed bench for arb_ram: latency-1 and latency-2 instances plus a small-array instance for the clear sweep.
`timescale 1ns/1ps
module tb_arb_ram;
   localparam int AW  = 10;
   localparam int AW3 = 4;
   localparam int DW  = 8;
   localparam int NP  = 2;
`ifdef RAM_CLEAR_ON_RESET_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   arb_ram_if #(.ADDR_WIDTH(AW),  .DATA_WIDTH(DW), .NUM_PORTS(NP)) b1 ();
   arb_ram_if #(.ADDR_WIDTH(AW),  .DATA_WIDTH(DW), .NUM_PORTS(NP)) b2 ();
   arb_ram_if #(.ADDR_WIDTH(AW3), .DATA_WIDTH(DW), .NUM_PORTS(NP)) b3 ();

   arb_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP), .READ_LATENCY(1))
      u_lat1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   arb_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP), .READ_LATENCY(2))
      u_lat2 (.clk(clk), .rst_n(rst_n), .bus(b2));
   arb_ram #(.ADDR_WIDTH(AW3), .DATA_WIDTH(DW), .NUM_PORTS(NP), .READ_LATENCY(1))
      u_small (.clk(clk), .rst_n(rst_n), .bus(b3));

   task automatic set1(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      b1.req[p] = 1'b1; b1.we[p] = w; b1.addr[p*AW +: AW] = a; b1.wdata[p*DW +: DW] = d;
   endtask

   task automatic set2(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      b2.req[p] = 1'b1; b2.we[p] = w; b2.addr[p*AW +: AW] = a; b2.wdata[p*DW +: DW] = d;
   endtask

   task automatic set3(input int p, input logic w, input logic [AW3-1:0] a, input logic [DW-1:0] d);
      b3.req[p] = 1'b1; b3.we[p] = w; b3.addr[p*AW3 +: AW3] = a; b3.wdata[p*DW +: DW] = d;
   endtask

   task automatic wait_idle(output bit timed_out);
      int n = 0;
      while ((b1.busy || b2.busy || b3.busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      timed_out = (n >= 3000);
   endtask

   task automatic test_reset();
      bit to;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (b1.gnt !== 2'b00) begin failures++; $display("FAIL rst_gnt got=%b exp=00", b1.gnt); end
      checks++; if (b1.rvalid !== 2'b00) begin failures++; $display("FAIL rst_rvalid got=%b exp=00", b1.rvalid); end
      checks++; if (b1.rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%h exp=00", b1.rdata); end
      checks++; if (b2.rvalid !== 2'b00 || b2.rdata !== 8'h00) begin failures++; $display("FAIL rst_lat2 got=%b/%h exp=00/00", b2.rvalid, b2.rdata); end
      checks++; if (b1.busy !== CLR_EN) begin failures++; $display("FAIL rst_busy got=%b exp=%b", b1.busy, CLR_EN); end
      @(negedge clk); rst_n = 1'b1;
      wait_idle(to);
      checks++; if (to) begin failures++; $display("FAIL rst_idle_timeout got=busy exp=idle"); end
      set1(0, 1'b0, 10'h000, 8'h00); set1(1, 1'b0, 10'h000, 8'h00);
      #1;
      checks++; if (b1.gnt !== 2'b01) begin failures++; $display("FAIL rst_first_gnt got=%b exp=01", b1.gnt); end
      b1.req = '0;
      @(negedge clk); #1;
      checks++; if (b1.rvalid !== 2'b00) begin failures++; $display("FAIL withdraw_rvalid got=%b exp=00", b1.rvalid); end
   endtask

   task automatic test_write_read();
      @(negedge clk); set1(0, 1'b1, 10'h200, 8'hAA); #1;
      checks++; if (b1.gnt !== 2'b01) begin failures++; $display("FAIL wr_gnt got=%b exp=01", b1.gnt); end
      @(negedge clk); #1;
      checks++; if (b1.rvalid !== 2'b00) begin failures++; $display("FAIL wr_no_rvalid got=%b exp=00", b1.rvalid); end
      set1(0, 1'b0, 10'h200, 8'h00); #1;
      checks++; if (b1.gnt !== 2'b01) begin failures++; $display("FAIL rd_gnt got=%b exp=01", b1.gnt); end
      @(negedge clk); b1.req = '0; #1;
      checks++; if (b1.rvalid !== 2'b01 || b1.rdata !== 8'hAA) begin failures++; $display("FAIL rd_data got=%b/%h exp=01/aa", b1.rvalid, b1.rdata); end
      @(negedge clk); #1;
      checks++; if (b1.rvalid !== 2'b00 || b1.rdata !== 8'hAA) begin failures++; $display("FAIL rd_hold got=%b/%h exp=00/aa", b1.rvalid, b1.rdata); end
   endtask

   task automatic test_round_robin();
      logic [1:0]    eg [4];
      logic [DW-1:0] ed [4];
      eg[0] = 2'b01; eg[1] = 2'b10; eg[2] = 2'b01; eg[3] = 2'b10;
      ed[0] = 8'h11; ed[1] = 8'h22; ed[2] = 8'h11; ed[3] = 8'h22;
      @(negedge clk); set1(0, 1'b1, 10'h010, 8'h11);
      @(negedge clk); b1.req = '0; set1(1, 1'b1, 10'h020, 8'h22);
      @(negedge clk); b1.req = '0;
      set1(0, 1'b0, 10'h010, 8'h00); set1(1, 1'b0, 10'h020, 8'h00);
      for (int c = 0; c < 5; c++) begin
         if (c == 4) b1.req = '0;
         #1;
         if (c < 4) begin
            checks++; if (b1.gnt !== eg[c]) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", c, b1.gnt, eg[c]); end
         end
         if (c > 0) begin
            checks++;
            if (b1.rvalid !== eg[c-1] || b1.rdata !== ed[c-1]) begin
               failures++; $display("FAIL rr_rd%0d got=%b/%h exp=%b/%h", c, b1.rvalid, b1.rdata, eg[c-1], ed[c-1]);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_write_then_read();
      set1(0, 1'b1, 10'h300, 8'h55); #1;
      checks++; if (b1.gnt !== 2'b01) begin failures++; $display("FAIL ord_wr_gnt got=%b exp=01", b1.gnt); end
      @(negedge clk); b1.req = '0; set1(1, 1'b0, 10'h300, 8'h00); #1;
      checks++; if (b1.gnt !== 2'b10) begin failures++; $display("FAIL ord_rd_gnt got=%b exp=10", b1.gnt); end
      @(negedge clk); b1.req = '0; #1;
      checks++; if (b1.rvalid !== 2'b10 || b1.rdata !== 8'h55) begin failures++; $display("FAIL ord_rd got=%b/%h exp=10/55", b1.rvalid, b1.rdata); end
      set1(0, 1'b1, 10'h300, 8'h66); set1(1, 1'b0, 10'h300, 8'h00); #1;
      checks++; if (b1.gnt !== 2'b01) begin failures++; $display("FAIL ord_both_gnt got=%b exp=01", b1.gnt); end
      @(negedge clk); b1.req[0] = 1'b0; #1;
      checks++; if (b1.gnt !== 2'b10) begin failures++; $display("FAIL ord_held_gnt got=%b exp=10", b1.gnt); end
      @(negedge clk); b1.req = '0; #1;
      checks++; if (b1.rvalid !== 2'b10 || b1.rdata !== 8'h66) begin failures++; $display("FAIL ord_both_rd got=%b/%h exp=10/66", b1.rvalid, b1.rdata); end
   endtask

   task automatic test_latency2();
      @(negedge clk); set2(0, 1'b1, 10'h1FF, 8'hFF); #1;
      checks++; if (b2.gnt !== 2'b01) begin failures++; $display("FAIL l2_wr_gnt got=%b exp=01", b2.gnt); end
      @(negedge clk); b2.req = '0; set2(1, 1'b0, 10'h1FF, 8'h00); #1;
      checks++; if (b2.gnt !== 2'b10) begin failures++; $display("FAIL l2_rd_gnt got=%b exp=10", b2.gnt); end
      @(negedge clk); b2.req = '0; #1;
      checks++; if (b2.rvalid !== 2'b00) begin failures++; $display("FAIL l2_early got=%b exp=00", b2.rvalid); end
      @(negedge clk); #1;
      checks++; if (b2.rvalid !== 2'b10 || b2.rdata !== 8'hFF) begin failures++; $display("FAIL l2_rd got=%b/%h exp=10/ff", b2.rvalid, b2.rdata); end
      @(negedge clk); #1;
      checks++; if (b2.rvalid !== 2'b00 || b2.rdata !== 8'hFF) begin failures++; $display("FAIL l2_hold got=%b/%h exp=00/ff", b2.rvalid, b2.rdata); end
      set2(0, 1'b0, 10'h1FF, 8'h00); set2(1, 1'b0, 10'h1FF, 8'h00); #1;
      checks++; if (b2.gnt !== 2'b01) begin failures++; $display("FAIL l2_pipe_gnt0 got=%b exp=01", b2.gnt); end
      @(negedge clk); b2.req[0] = 1'b0; #1;
      checks++; if (b2.gnt !== 2'b10 || b2.rvalid !== 2'b00) begin failures++; $display("FAIL l2_pipe_gnt1 got=%b/%b exp=10/00", b2.gnt, b2.rvalid); end
      @(negedge clk); b2.req = '0; #1;
      checks++; if (b2.rvalid !== 2'b01) begin failures++; $display("FAIL l2_pipe_v0 got=%b exp=01", b2.rvalid); end
      @(negedge clk); #1;
      checks++; if (b2.rvalid !== 2'b10) begin failures++; $display("FAIL l2_pipe_v1 got=%b exp=10", b2.rvalid); end
   endtask

   task automatic test_mid_reset();
      bit to;
      @(negedge clk); set1(0, 1'b0, 10'h200, 8'h00); #1;
      checks++; if (b1.gnt !== 2'b01) begin failures++; $display("FAIL mr_gnt got=%b exp=01", b1.gnt); end
      @(posedge clk); #2; rst_n = 1'b0; b1.req = '0;
      @(negedge clk); #1;
      checks++; if (b1.rvalid !== 2'b00) begin failures++; $display("FAIL mr_in_reset got=%b exp=00", b1.rvalid); end
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (b1.rvalid !== 2'b00) begin failures++; $display("FAIL mr_after%0d got=%b exp=00", c, b1.rvalid); end
         @(negedge clk);
      end
      wait_idle(to);
      checks++; if (to) begin failures++; $display("FAIL mr_idle_timeout got=busy exp=idle"); end
      set1(0, 1'b0, 10'h000, 8'h00); set1(1, 1'b0, 10'h000, 8'h00); #1;
      checks++; if (b1.gnt !== 2'b01) begin failures++; $display("FAIL mr_first_gnt got=%b exp=01", b1.gnt); end
      b1.req = '0;
   endtask

   task automatic test_persist();
`ifndef RAM_CLEAR_ON_RESET_EN
      @(negedge clk); set1(0, 1'b0, 10'h300, 8'h00);
      @(negedge clk); b1.req = '0; #1;
      checks++; if (b1.rvalid !== 2'b01 || b1.rdata !== 8'h66) begin failures++; $display("FAIL persist got=%b/%h exp=01/66", b1.rvalid, b1.rdata); end
      checks++; if (b3.busy !== 1'b0) begin failures++; $display("FAIL busy_tied got=%b exp=0", b3.busy); end
`endif
   endtask

   task automatic test_clear();
`ifdef RAM_CLEAR_ON_RESET_EN
      int n;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk); set3(0, 1'b1, 4'(i), 8'hFF);
      end
      @(negedge clk); b3.req = '0;
      rst_n = 1'b0;
      set3(1, 1'b0, 4'h5, 8'h00);
      @(negedge clk); rst_n = 1'b1;
      n = 0;
      while (b3.busy && n < 64) begin
         checks++; if (b3.gnt !== 2'b00) begin failures++; $display("FAIL clr_gnt_busy got=%b exp=00", b3.gnt); end
         @(negedge clk);
         n++;
      end
      checks++; if (n != 16) begin failures++; $display("FAIL clr_busy_cycles got=%0d exp=16", n); end
      #1;
      checks++; if (b3.gnt !== 2'b10) begin failures++; $display("FAIL clr_req_kept got=%b exp=10", b3.gnt); end
      for (int i = 0; i < 17; i++) begin
         if (i < 16) b3.addr[AW3 +: AW3] = 4'(i);
         else b3.req = '0;
         #1;
         if (i > 0) begin
            checks++;
            if (b3.rvalid !== 2'b10 || b3.rdata !== 8'h00) begin
               failures++; $display("FAIL clr_rd%0d got=%b/%h exp=10/00", i-1, b3.rvalid, b3.rdata);
            end
         end
         @(negedge clk);
      end
`endif
   endtask

   initial begin
      b1.req = '0; b1.we = '0; b1.addr = '0; b1.wdata = '0;
      b2.req = '0; b2.we = '0; b2.addr = '0; b2.wdata = '0;
      b3.req = '0; b3.we = '0; b3.addr = '0; b3.wdata = '0;
      test_reset();
      test_write_read();
      test_round_robin();
      test_write_then_read();
      test_latency2();
      test_mid_reset();
      test_persist();
      test_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "tb_arb_ram watchdog");
   end
endmodule
